bcd_count_2dig: RTL and testbench

Two-digit BCD up/down timer/counter that feeds the seven-segment digit multiplexer. It produces the units and tens digits (data0, data1) from a 1 Hz prescaled tick, controlled by two debounced board keys (start/stop, clear) and a direction switch. It sits directly upstream of the display-select stage; outputs are registered 4-bit BCD digits in range 0-9.

---
 rtl/bcd_count_2dig_pkg.sv | 62 ++++++
 rtl/bcd_count_2dig_key.sv | 46 ++++
 rtl/bcd_count_2dig.sv | 117 +++++++++++
 tb/tb_bcd_count_2dig.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/bcd_count_2dig_pkg.sv
// Shared definitions for the two-digit BCD counter: state encoding, digit width,
// default timing constants and the BCD step helper.
package bcd_count_2dig_pkg;

    localparam int unsigned DIGIT_W        = 4;
    localparam int unsigned DEF_TICK_DIV   = 50_000_000;
    localparam int unsigned DEF_DEB_CYCLES = 1_000_000;
    localparam int unsigned DEF_MAX_VAL    = 59;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_t;

    typedef logic [DIGIT_W-1:0] digit_t;

    typedef struct packed {
        logic   wrap;
        digit_t tens;
        digit_t ones;
    } bcd_step_t;

    // One BCD step up or down; wraps between 0 and the (max_tens, max_ones) value.
    function automatic bcd_step_t bcd_step(
        input digit_t tens,
        input digit_t ones,
        input logic   up,
        input digit_t max_tens,
        input digit_t max_ones
    );
        bcd_step_t r;
        r.wrap = 1'b0;
        r.tens = tens;
        r.ones = ones;
        if (up) begin
            if (tens == max_tens && ones == max_ones) begin
                r.tens = '0;
                r.ones = '0;
                r.wrap = 1'b1;
            end else if (ones >= 4'd9) begin
                r.ones = '0;
                r.tens = tens + 4'd1;
            end else begin
                r.ones = ones + 4'd1;
            end
        end else begin
            if (tens == '0 && ones == '0) begin
                r.tens = max_tens;
                r.ones = max_ones;
                r.wrap = 1'b1;
            end else if (ones == '0) begin
                r.ones = 4'd9;
                r.tens = tens - 4'd1;
            end else begin
                r.ones = ones - 4'd1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd_count_2dig_key.sv
// Key conditioner: two-flop synchronizer, stability counter and a one-cycle
// pulse on each accepted released->pressed transition.
module key_debounce
    import bcd_count_2dig_pkg::*;
#(
    parameter int unsigned DEB_CYCLES = DEF_DEB_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n,
    output logic press
);

    localparam int unsigned CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

    logic          sync1;
    logic          sync2;
    logic          level_n;
    logic [CW-1:0] cnt;

    // The accepted level follows the synced key only after DEB_CYCLES
    // consecutive disagreeing samples; any agreement restarts the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1   <= 1'b1;
            sync2   <= 1'b1;
            level_n <= 1'b1;
            cnt     <= '0;
            press   <= 1'b0;
        end else begin
            sync1 <= key_n;
            sync2 <= sync1;
            press <= 1'b0;
            if (sync2 == level_n) begin
                cnt <= '0;
            end else if (cnt == CW'(DEB_CYCLES - 1)) begin
                cnt     <= '0;
                level_n <= sync2;
                press   <= ~sync2;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/bcd_count_2dig.sv
// Two-digit BCD up/down counter with run/pause/clear keys and a prescaled tick;
// drives the units/tens digits for the seven-segment multiplexer.
module bcd_count_2dig
    import bcd_count_2dig_pkg::*;
#(
    parameter int unsigned TICK_DIV   = DEF_TICK_DIV,
    parameter int unsigned DEB_CYCLES = DEF_DEB_CYCLES,
    parameter int unsigned MAX_VAL    = DEF_MAX_VAL
) (
    input  logic               FPGA_CLK,
    input  logic               FPGA_RST_N,
    input  logic               key_run_n,
    input  logic               key_clr_n,
    input  logic               dir_up,
    output logic [DIGIT_W-1:0] data0,
    output logic [DIGIT_W-1:0] data1,
    output logic               running,
    output logic               wrap
);

    localparam int unsigned TW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam digit_t      MAX_TENS = DIGIT_W'(MAX_VAL / 10);
    localparam digit_t      MAX_ONES = DIGIT_W'(MAX_VAL % 10);

    logic          run_press;
    logic          clr_press;
    logic          dir_meta;
    logic          dir_sync;
    logic [TW-1:0] tick_cnt;
    logic          tick;
    state_t        state;
    state_t        next_state;
    bcd_step_t     step;

    key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_run_key (
        .clk   (FPGA_CLK),
        .rst_n (FPGA_RST_N),
        .key_n (key_run_n),
        .press (run_press)
    );

    key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_clr_key (
        .clk   (FPGA_CLK),
        .rst_n (FPGA_RST_N),
        .key_n (key_clr_n),
        .press (clr_press)
    );

    always_ff @(posedge FPGA_CLK or negedge FPGA_RST_N) begin
        if (!FPGA_RST_N) begin
            dir_meta <= 1'b1;
            dir_sync <= 1'b1;
        end else begin
            dir_meta <= dir_up;
            dir_sync <= dir_meta;
        end
    end

    always_ff @(posedge FPGA_CLK or negedge FPGA_RST_N) begin
        if (!FPGA_RST_N) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        if (clr_press) begin
            next_state = ST_IDLE;
        end else if (run_press) begin
            unique case (state)
                ST_IDLE:  next_state = ST_RUN;
                ST_RUN:   next_state = ST_PAUSE;
                ST_PAUSE: next_state = ST_RUN;
                default:  next_state = ST_IDLE;
            endcase
        end
    end

    assign running = (state == ST_RUN);
    assign tick    = running && (tick_cnt == TW'(TICK_DIV - 1));

    // Held at zero outside RUN, so every entry into RUN sees a full interval.
    always_ff @(posedge FPGA_CLK or negedge FPGA_RST_N) begin
        if (!FPGA_RST_N) begin
            tick_cnt <= '0;
        end else if (!running || tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + TW'(1);
        end
    end

    always_comb begin
        step = bcd_step(data1, data0, dir_sync, MAX_TENS, MAX_ONES);
    end

    always_ff @(posedge FPGA_CLK or negedge FPGA_RST_N) begin
        if (!FPGA_RST_N) begin
            data0 <= '0;
            data1 <= '0;
            wrap  <= 1'b0;
        end else begin
            wrap <= 1'b0;
            if (clr_press) begin
                data0 <= '0;
                data1 <= '0;
            end else if (tick) begin
                data0 <= step.ones;
                data1 <= step.tens;
                wrap  <= step.wrap;
            end
        end
    end

endmodule

// File: tb/tb_bcd_count_2dig.sv
// Scoreboard bench for bcd_count_2dig: stimulus queues expected output changes
// with their cycle numbers, a negedge monitor pops and compares each change.
module tb_bcd_count_2dig;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       key_run_n = 1'b1;
    logic       key_clr_n = 1'b1;
    logic       dir_up = 1'b1;
    logic [3:0] data0;
    logic [3:0] data1;
    logic       running;
    logic       wrap;

    bcd_count_2dig #(
        .TICK_DIV   (10),
        .DEB_CYCLES (4),
        .MAX_VAL    (59)
    ) dut (
        .FPGA_CLK   (clk),
        .FPGA_RST_N (rst_n),
        .key_run_n  (key_run_n),
        .key_clr_n  (key_clr_n),
        .dir_up     (dir_up),
        .data0      (data0),
        .data1      (data1),
        .running    (running),
        .wrap       (wrap)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  d1;
        logic [3:0]  d0;
        logic        run;
        logic        wr;
        logic [31:0] cyc;
    } exp_t;

    exp_t       exp_q[$];
    string      chk_name[$];
    logic [3:0] chk_got[$];
    logic [3:0] chk_want[$];
    int         cyc = 0;
    int         total = 0;
    int         bad = 0;
    bit         done = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void exp_val(input int v, input bit r, input bit w, input int c);
        exp_t e;
        e.d1  = 4'(v / 10);
        e.d0  = 4'(v % 10);
        e.run = r;
        e.wr  = w;
        e.cyc = 32'(c);
        exp_q.push_back(e);
    endfunction

    task automatic wait_until(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    // Monitor: every change of the output tuple is one scoreboard event.
    logic [9:0] prev;
    bit         have_prev = 1'b0;
    always @(negedge clk) begin
        logic [9:0] obs;
        exp_t       e;
        obs = {data1, data0, running, wrap};
        if (!have_prev || obs !== prev) begin
            have_prev = 1'b1;
            prev = obs;
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_change cyc=%0d got d1=%0d d0=%0d run=%0b wrap=%0b want no change",
                         cyc, data1, data0, running, wrap);
            end else begin
                e = exp_q.pop_front();
                if (obs !== {e.d1, e.d0, e.run, e.wr}) begin
                    bad++;
                    $display("FAIL value cyc=%0d got d1=%0d d0=%0d run=%0b wrap=%0b want d1=%0d d0=%0d run=%0b wrap=%0b",
                             cyc, data1, data0, running, wrap, e.d1, e.d0, e.run, e.wr);
                end
                total++;
                if (32'(cyc) != e.cyc) begin
                    bad++;
                    $display("FAIL timing got cyc=%0d want cyc=%0d (d1=%0d d0=%0d)", cyc, e.cyc, e.d1, e.d0);
                end
            end
        end
        while (chk_name.size() > 0) begin
            string      n;
            logic [3:0] g;
            logic [3:0] w;
            n = chk_name.pop_front();
            g = chk_got.pop_front();
            w = chk_want.pop_front();
            total++;
            if (g !== w) begin
                bad++;
                $display("FAIL %s got=%0d want=%0d", n, g, w);
            end
        end
        if (done) begin
            total++;
            if (exp_q.size() != 0) begin
                bad++;
                $display("FAIL pending_events got=%0d want=0", exp_q.size());
            end
            $display("test done: total=%0d bad=%0d", total, bad);
            $finish;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, t0, r, c3, c4, v;

        exp_val(0, 0, 0, 1);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (100) @(negedge clk);

        // Whole run timeline relative to the first run press.
        c0 = cyc;
        t0 = c0 + 7;
        exp_val(0, 1, 0, t0);
        for (int k = 1; k <= 59; k++) exp_val(k, 1, 0, t0 + 10 * k);
        exp_val(0, 1, 1, t0 + 600);
        exp_val(0, 1, 0, t0 + 601);
        for (int k = 1; k <= 23; k++) exp_val(k, 1, 0, t0 + 600 + 10 * k);
        exp_val(23, 0, 0, t0 + 832);
        r = t0 + 889;
        exp_val(23, 1, 0, r);
        exp_val(24, 1, 0, r + 10);
        for (int k = 2; k <= 48; k++) begin
            if (k == 26) begin
                exp_val(59, 1, 1, r + 260);
                exp_val(59, 1, 0, r + 261);
            end else begin
                v = (k <= 25) ? (25 - k) : (85 - k);
                exp_val(v, 1, 0, r + 10 * k);
            end
        end
        c3 = r + 478;
        exp_val(0, 0, 0, c3 + 7);
        c4 = c3 + 40;
        exp_val(0, 1, 0, c4 + 7);
        exp_val(1, 1, 0, c4 + 17);
        exp_val(2, 1, 0, c4 + 27);
        exp_val(0, 0, 0, c4 + 33);

        key_run_n = 1'b0;
        repeat (20) @(negedge clk);
        key_run_n = 1'b1;

        wait_until(t0 + 50);
        key_run_n = 1'b0;
        repeat (2) @(negedge clk);
        key_run_n = 1'b1;
        @(negedge clk);
        key_run_n = 1'b0;
        repeat (2) @(negedge clk);
        key_run_n = 1'b1;

        wait_until(t0 + 825);
        key_run_n = 1'b0;
        repeat (20) @(negedge clk);
        key_run_n = 1'b1;

        wait_until(t0 + 882);
        key_run_n = 1'b0;
        repeat (20) @(negedge clk);
        key_run_n = 1'b1;

        wait_until(r + 15);
        dir_up = 1'b0;

        wait_until(c3);
        key_run_n = 1'b0;
        key_clr_n = 1'b0;
        repeat (20) @(negedge clk);
        key_run_n = 1'b1;
        key_clr_n = 1'b1;
        dir_up = 1'b1;

        wait_until(c4);
        key_run_n = 1'b0;
        repeat (20) @(negedge clk);
        key_run_n = 1'b1;

        wait_until(c4 + 32);
        #2 rst_n = 1'b0;
        #1;
        chk_name.push_back("rst_data0");   chk_got.push_back(data0);          chk_want.push_back(4'd0);
        chk_name.push_back("rst_data1");   chk_got.push_back(data1);          chk_want.push_back(4'd0);
        chk_name.push_back("rst_running"); chk_got.push_back({3'b0, running}); chk_want.push_back(4'd0);
        chk_name.push_back("rst_wrap");    chk_got.push_back({3'b0, wrap});    chk_want.push_back(4'd0);

        wait_until(c4 + 40);
        rst_n = 1'b1;
        repeat (50) @(negedge clk);
        for (int i = 0; i < 100 && exp_q.size() > 0; i++) @(negedge clk);
        done = 1'b1;
    end

endmodule
